// File: rtl/alu_core.sv
// RV32I integer ALU plus branch comparator.
// Result word and branch flag are both registered, one cycle of latency.
module alu_core (
    input  logic        clk,
    input  logic        rts,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        cmp
);

    logic [4:0]  shamt;
    logic        alt;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] sll_r;
    logic [31:0] srl_r;
    logic [31:0] sra_r;
    logic [31:0] res_d;
    logic        cmp_d;

    assign shamt = b[4:0];
    assign alt   = op[3];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);
    assign sum   = a + b;
    assign diff  = a - b;
    assign sll_r = a << shamt;
    assign srl_r = a >> shamt;
    assign sra_r = $unsigned($signed(a) >>> shamt);

    always_comb begin
        res_d = '0;
        case (op[2:0])
            3'd0: res_d = alt ? diff : sum;
            3'd1: res_d = sll_r;
            3'd2: res_d = {31'd0, lt_s};
            3'd3: res_d = {31'd0, lt_u};
            3'd4: res_d = a ^ b;
            3'd5: res_d = alt ? sra_r : srl_r;
            3'd6: res_d = a | b;
            3'd7: res_d = a & b;
            default: res_d = '0;
        endcase
    end

    // Branch conditions follow funct3 only; codes 2 and 3 have no branch.
    always_comb begin
        cmp_d = 1'b0;
        case (op[2:0])
            3'd0: cmp_d = eq;
            3'd1: cmp_d = !eq;
            3'd4: cmp_d = lt_s;
            3'd5: cmp_d = !lt_s;
            3'd6: cmp_d = lt_u;
            3'd7: cmp_d = !lt_u;
            default: cmp_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            out <= '0;
            cmp <= 1'b0;
        end else begin
            out <= res_d;
            cmp <= cmp_d;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed and random checks of alu_core against an arithmetic reference.
module tb_alu_core;

    logic        clk;
    logic        rts;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        cmp;

    int n_checks;
    int n_fail;

    alu_core dut (
        .clk(clk),
        .rts(rts),
        .op (op),
        .a  (a),
        .b  (b),
        .out(out),
        .cmp(cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_out(input logic [3:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        longint unsigned ux;
        longint unsigned uy;
        longint sx;
        longint sy;
        int sh;
        logic [31:0] r;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y % 32);
        r = '0;
        if (o[2:0] == 3'd0)
            r = o[3] ? 32'((ux + 64'h1_0000_0000 - uy) % 64'h1_0000_0000)
                     : 32'((ux + uy) % 64'h1_0000_0000);
        else if (o[2:0] == 3'd1)
            r = 32'((ux * (64'd1 << sh)) % 64'h1_0000_0000);
        else if (o[2:0] == 3'd2)
            r = (sx < sy) ? 32'd1 : 32'd0;
        else if (o[2:0] == 3'd3)
            r = (ux < uy) ? 32'd1 : 32'd0;
        else if (o[2:0] == 3'd4)
            r = x ^ y;
        else if (o[2:0] == 3'd5) begin
            // Arithmetic shift as floor division by a power of two.
            if (o[3]) begin
                if (sx >= 0) r = 32'(sx / (64'sd1 <<< sh));
                else r = 32'(-((-sx + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh)));
            end else begin
                r = 32'(ux / (64'd1 << sh));
            end
        end
        else if (o[2:0] == 3'd6)
            r = x | y;
        else
            r = x & y;
        return r;
    endfunction

    function automatic logic ref_cmp(input logic [3:0] o,
                                     input logic [31:0] x,
                                     input logic [31:0] y);
        longint sx;
        longint sy;
        longint unsigned ux;
        longint unsigned uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        case (o[2:0])
            3'd0: return ux == uy;
            3'd1: return ux != uy;
            3'd4: return sx < sy;
            3'd5: return sx >= sy;
            3'd6: return ux < uy;
            3'd7: return ux >= uy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk32(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
    endtask

    task automatic step_out(input string tag, input logic [3:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp);
        apply(o, x, y);
        chk32(tag, out, exp);
    endtask

    task automatic step_cmp(input string tag, input logic [3:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic exp);
        apply(o, x, y);
        chk1(tag, cmp, exp);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_fail   = 0;
        rts = 1'b1;
        op  = 4'd0;
        a   = 32'd5;
        b   = 32'd7;
        #1;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk32("reset_out", out, 32'd0);
            chk1("reset_cmp", cmp, 1'b0);
        end
        rts = 1'b0;
        @(posedge clk);
        #1;
        chk32("first_add", out, 32'd12);
        chk1("first_beq", cmp, 1'b0);

        step_out("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        step_out("sub_wrap", 4'h8, 32'h0, 32'd1, 32'hFFFF_FFFF);
        step_out("xor", 4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        step_out("or",  4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        step_out("and", 4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        step_out("xor_alt", 4'hC, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);

        step_out("sll", 4'h1, 32'h8000_0001, 32'h21, 32'h0000_0002);
        step_out("srl", 4'h5, 32'h8000_0001, 32'h21, 32'h4000_0000);
        step_out("sra", 4'hD, 32'h8000_0001, 32'h21, 32'hC000_0000);
        step_out("sra31", 4'hD, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        step_out("srl31", 4'h5, 32'h8000_0000, 32'd31, 32'h0000_0001);
        step_out("sll0", 4'h1, 32'h1234_5678, 32'h20, 32'h1234_5678);
        step_out("sll31", 4'h1, 32'h0000_0003, 32'd31, 32'h8000_0000);

        step_out("slt", 4'h2, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        step_out("sltu", 4'h3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
        step_out("slt_eq", 4'h2, 32'h1357_9BDF, 32'h1357_9BDF, 32'd0);
        step_out("sltu_eq", 4'h3, 32'h1357_9BDF, 32'h1357_9BDF, 32'd0);

        step_cmp("beq",  4'h0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step_cmp("bne",  4'h1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step_cmp("blt",  4'h4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step_cmp("bge",  4'h5, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step_cmp("bltu", 4'h6, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step_cmp("bgeu", 4'h7, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step_cmp("br2",  4'h2, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step_cmp("br3",  4'h3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step_cmp("bge_alt_eq", 4'hD, 32'hABCD_0123, 32'hABCD_0123, 1'b1);
        step_cmp("beq_eq", 4'h0, 32'h0000_0042, 32'h0000_0042, 1'b1);

        // Every op code once, against the reference
        for (int k = 0; k < 16; k++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 4'(k);
            apply(ro, ra, rb);
            chk32("op_sweep_out", out, ref_out(ro, ra, rb));
            chk1("op_sweep_cmp", cmp, ref_cmp(ro, ra, rb));
        end

        // Back-to-back random stream with a reset pulse in the middle
        for (int k = 0; k < 8; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (k % 3 == 0) ? ra : $urandom;
            rts = (k == 4);
            apply(ro, ra, rb);
            if (k == 4) begin
                chk32("mid_reset_out", out, 32'd0);
                chk1("mid_reset_cmp", cmp, 1'b0);
            end else begin
                chk32("stream_out", out, ref_out(ro, ra, rb));
                chk1("stream_cmp", cmp, ref_cmp(ro, ra, rb));
            end
        end
        rts = 1'b0;

        for (int k = 0; k < 200; k++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (k % 7 == 0) ? ra : $urandom;
            apply(ro, ra, rb);
            chk32("rand_out", out, ref_out(ro, ra, rb));
            chk1("rand_cmp", cmp, ref_cmp(ro, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
